// File: rtl/vote_session_ctrl.sv
// Ballot-sequencing controller: one vote per officer arm, saturating per-candidate
// tallies with running total, post-vote lockout and a registered tally readout mode.
module vote_session_ctrl #(
  parameter  int NUM_CAND    = 4,
  parameter  int CNT_W       = 8,
  parameter  int LOCK_CYCLES = 20,
  localparam int SEL_W       = $clog2(NUM_CAND),
  localparam int TOT_W       = CNT_W + SEL_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                arm,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] validVote,
  input  logic [SEL_W-1:0]    result_sel,
  output logic                ready,
  output logic                cast_done,
  output logic                ballot_err,
  output logic [NUM_CAND-1:0] cast_onehot,
  output logic [CNT_W-1:0]    vote_count,
  output logic [TOT_W-1:0]    total_votes
);

  localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RECORD  = 3'd2,
    LOCKOUT = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_tally [NUM_CAND];
  logic [TOT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_vote_count;
  logic [NUM_CAND-1:0] r_onehot;
  logic                r_err;
  logic [LCK_W-1:0]    r_lock;
  logic [SEL_W-1:0]    r_cand;

  logic [NUM_CAND-1:0] w_low;
  logic                w_any;
  logic                w_one;
  logic                w_multi;
  logic [SEL_W-1:0]    w_idx;

  // Clearing the lowest set bit leaves zero exactly when one button is pressed.
  always_comb begin
    w_low   = validVote & (validVote - NUM_CAND'(1));
    w_any   = |validVote;
    w_one   = w_any && (w_low == '0);
    w_multi = w_any && (w_low != '0);
    w_idx   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (validVote[i]) w_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_total      <= '0;
      r_vote_count <= '0;
      r_onehot     <= '0;
      r_err        <= 1'b0;
      r_lock       <= '0;
      r_cand       <= '0;
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mode)     r_state <= RESULT;
          else if (arm) r_state <= ARMED;
        end
        ARMED: begin
          if (w_one) begin
            r_cand  <= w_idx;
            r_state <= RECORD;
          end else if (w_multi) begin
            r_err <= 1'b1;
          end
        end
        RECORD: begin
          if (r_tally[r_cand] != {CNT_W{1'b1}}) begin
            r_tally[r_cand] <= r_tally[r_cand] + CNT_W'(1);
            r_total         <= r_total + TOT_W'(1);
          end
          r_onehot <= NUM_CAND'(1) << r_cand;
          r_lock   <= LCK_W'(LOCK_CYCLES - 1);
          r_state  <= LOCKOUT;
        end
        LOCKOUT: begin
          if (r_lock == '0) r_state <= IDLE;
          else              r_lock  <= r_lock - LCK_W'(1);
        end
        RESULT: begin
          // Out-of-range selects only exist when NUM_CAND is not a power of two.
          r_vote_count <= (32'(result_sel) < NUM_CAND) ? r_tally[result_sel] : '0;
          if (!mode) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready       = (r_state == ARMED);
  assign cast_done   = (r_state == RECORD);
  assign ballot_err  = r_err;
  assign cast_onehot = r_onehot;
  assign vote_count  = r_vote_count;
  assign total_votes = r_total;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: directed scenarios plus random traffic
// compared every cycle against a phase/counter reference model.
module tb_vote_session_ctrl;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int LC = 4;
  localparam int SW = 2;
  localparam int TW = CW + SW;

  logic          clock = 1'b0;
  logic          reset;
  logic          arm;
  logic          mode;
  logic [NC-1:0] validVote;
  logic [SW-1:0] result_sel;
  logic          ready;
  logic          cast_done;
  logic          ballot_err;
  logic [NC-1:0] cast_onehot;
  logic [CW-1:0] vote_count;
  logic [TW-1:0] total_votes;

  vote_session_ctrl #(
    .NUM_CAND   (NC),
    .CNT_W      (CW),
    .LOCK_CYCLES(LC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .mode       (mode),
    .validVote  (validVote),
    .result_sel (result_sel),
    .ready      (ready),
    .cast_done  (cast_done),
    .ballot_err (ballot_err),
    .cast_onehot(cast_onehot),
    .vote_count (vote_count),
    .total_votes(total_votes)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: ballot open / recording / remaining lockout cycles / readout.
  bit m_open;
  bit m_rec;
  int m_lock;
  bit m_res;
  bit m_err;
  int m_cand;
  int m_tally [NC];
  int m_total;
  int m_vc;
  int m_onehot;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_open = 0; m_rec = 0; m_lock = 0; m_res = 0; m_err = 0; m_cand = 0;
    m_total = 0; m_vc = 0; m_onehot = 0;
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
  endtask

  task automatic model_update(input bit a, input bit m, input logic [NC-1:0] v,
                              input int s, input bit r);
    bit idle;
    idle = !m_open && !m_rec && (m_lock == 0) && !m_res;
    if (r) begin
      model_clear();
    end else begin
      m_err = 0;
      if (idle) begin
        if (m)      m_res  = 1;
        else if (a) m_open = 1;
      end else if (m_open) begin
        if ($countones(v) == 1) begin
          m_open = 0;
          m_rec  = 1;
          m_cand = $clog2(v);
        end else if ($countones(v) > 1) begin
          m_err = 1;
        end
      end else if (m_rec) begin
        if (m_tally[m_cand] < (2**CW) - 1) begin
          m_tally[m_cand]++;
          m_total++;
        end
        m_onehot = 1 << m_cand;
        m_rec    = 0;
        m_lock   = LC;
      end else if (m_lock > 0) begin
        m_lock--;
      end else if (m_res) begin
        m_vc = (s < NC) ? m_tally[s] : 0;
        if (!m) m_res = 0;
      end
    end
  endtask

  task automatic step(input bit a, input bit m, input logic [NC-1:0] v,
                      input int s, input bit r);
    arm        = a;
    mode       = m;
    validVote  = v;
    result_sel = SW'(s);
    reset      = r;
    @(posedge clock);
    model_update(a, m, v, s, r);
    #1;
    check_val("ready",       ready,       m_open);
    check_val("cast_done",   cast_done,   m_rec);
    check_val("ballot_err",  ballot_err,  m_err);
    check_val("cast_onehot", cast_onehot, m_onehot);
    check_val("vote_count",  vote_count,  m_vc);
    check_val("total_votes", total_votes, m_total);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic cast(input int c);
    step(1, 0, '0, 0, 0);
    step(0, 0, NC'(1) << c, 0, 0);
    idle_cycles(LC + 1);
  endtask

  initial begin
    model_clear();
    arm = 0; mode = 0; validVote = '0; result_sel = '0; reset = 1;

    // Reset state
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    check_val("rst_total", total_votes, 0);
    check_val("rst_ready", ready, 0);

    // Single vote for candidate 2
    step(1, 0, '0, 0, 0);
    check_val("sv_ready", ready, 1);
    step(0, 0, 4'b0100, 0, 0);
    check_val("sv_cast_done", cast_done, 1);
    step(0, 0, '0, 0, 0);
    check_val("sv_onehot", cast_onehot, 4'b0100);
    check_val("sv_total", total_votes, 1);
    idle_cycles(LC - 1);
    step(1, 0, '0, 0, 0);
    check_val("sv_idle_after_lock", ready, 0);
    step(1, 0, '0, 0, 0);
    check_val("sv_rearm", ready, 1);

    // Collision then valid vote for candidate 0
    step(0, 0, 4'b0011, 0, 0);
    check_val("col_err", ballot_err, 1);
    check_val("col_ready", ready, 1);
    step(0, 0, 4'b0001, 0, 0);
    check_val("col_err_clear", ballot_err, 0);
    idle_cycles(LC + 1);
    check_val("col_total", total_votes, 2);

    // Presses while idle and during lockout; arm during lockout
    step(0, 0, 4'b1000, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, 4'b0010, 0, 0);
    for (int i = 0; i < LC + 1; i++) step(1, 0, 4'b1000, 0, 0);
    step(0, 0, 4'b1000, 0, 0);
    check_val("lock_total", total_votes, 3);
    check_val("lock_no_cast", cast_done, 0);

    // Saturation on candidate 1
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 256; i++) cast(1);
    check_val("sat_total", total_votes, 255);
    step(0, 1, '0, 1, 0);
    step(0, 1, '0, 1, 0);
    check_val("sat_tally", vote_count, 255);
    step(0, 0, '0, 1, 0);

    // Readout after votes {3,0,5,1}
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cast(0);
    for (int i = 0; i < 5; i++) cast(2);
    cast(3);
    step(0, 1, '0, 2, 0);
    step(0, 1, '0, 2, 0);
    check_val("rd_sel2", vote_count, 5);
    step(0, 1, '0, 3, 0);
    check_val("rd_sel3", vote_count, 1);
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check_val("rd_back_idle", ready, 1);
    step(0, 0, '0, 0, 0);

    // Reset during RECORD
    step(0, 0, '0, 0, 1);
    step(1, 0, '0, 0, 0);
    step(0, 0, 4'b0001, 0, 0);
    check_val("rr_in_record", cast_done, 1);
    step(0, 0, '0, 0, 1);
    check_val("rr_total", total_votes, 0);
    check_val("rr_onehot", cast_onehot, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    check_val("rr_tally0", vote_count, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit r, a, m;
      logic [NC-1:0] v;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 99) < 30);
      m = ($urandom_range(0, 99) < 15);
      v = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom_range(0, 15));
      step(a, m, v, $urandom_range(0, NC - 1), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
